otp_auth_ctrl: RTL and testbench

Parametrised OTP authentication controller, the next generation of the fixed 4-digit lock FSM. It latches an N-digit OTP from the generator and collects user digits from the keypad front end. It supports a clear key, compares the entry, and counts wrong attempts up to a configurable limit. It drives timed unlock, expired and lockout indications, with all digit counts and timeouts set by parameters.

---
 rtl/otp_auth_pkg.sv | 19 +
 rtl/otp_entry_buf.sv | 59 +++++
 rtl/otp_auth_ctrl.sv | 171 +++++++++++++++++
 tb/tb_otp_auth_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_auth_pkg.sv
// Shared types and width helpers for the OTP authentication controller.
package otp_auth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    ENTER   = 3'd2,
    CHECK   = 3'd3,
    UNLOCK  = 3'd4,
    EXPIRED = 3'd5,
    LOCKOUT = 3'd6
  } state_e;

  // Bits needed to hold every value from 0 up to and including n.
  function automatic int cnt_w(input longint unsigned n);
    return $clog2(n + 64'd1);
  endfunction

endpackage

// File: rtl/otp_entry_buf.sv
// Keypad entry buffer: digits fill from the MSB end, count tracks how many are held.
module otp_entry_buf
  import otp_auth_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int DIGIT_W  = 4,
  localparam int ENT_W   = N_DIGITS * DIGIT_W,
  localparam int CNT_W   = cnt_w(N_DIGITS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] digit,
  output logic [ENT_W-1:0]   entry,
  output logic [CNT_W-1:0]   count,
  output logic               full
);

  logic [ENT_W-1:0] entry_r, entry_n;
  logic [CNT_W-1:0] count_r, count_n;
  logic             full_s;
  int               slot_s;

  assign full_s = (count_r == CNT_W'(N_DIGITS));
  assign slot_s = N_DIGITS - 1 - int'(count_r);

  // Next buffer contents: clear wins over write, writes beyond full are dropped.
  always_comb begin
    entry_n = entry_r;
    count_n = count_r;
    if (clr) begin
      entry_n = {ENT_W{1'b0}};
      count_n = {CNT_W{1'b0}};
    end else if (wr && !full_s) begin
      entry_n[slot_s*DIGIT_W +: DIGIT_W] = digit;
      count_n = count_r + CNT_W'(1'b1);
    end else begin
      entry_n = entry_r;
      count_n = count_r;
    end
  end

  // Buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_r <= {ENT_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      entry_r <= entry_n;
      count_r <= count_n;
    end
  end

  assign entry = entry_r;
  assign count = count_r;
  assign full  = full_s;

endmodule

// File: rtl/otp_auth_ctrl.sv
// OTP authentication controller: loads an OTP, collects keypad digits, compares,
// counts wrong attempts and raises timed unlock / expired / lockout indications.
module otp_auth_ctrl
  import otp_auth_pkg::*;
#(
  parameter int              N_DIGITS      = 4,
  parameter int              DIGIT_W       = 4,
  parameter int              MAX_ATTEMPTS  = 3,
  parameter longint unsigned EXPIRE_CYCLES = 64'd2_500_000_000,
  parameter longint unsigned HOLD_CYCLES   = 64'd250_000_000,
  localparam int OTP_W   = N_DIGITS * DIGIT_W,
  localparam int ATT_W   = cnt_w(MAX_ATTEMPTS),
  localparam int CNT_W   = cnt_w(N_DIGITS),
  localparam int TIMER_W = cnt_w(EXPIRE_CYCLES),
  localparam int HOLD_W  = cnt_w(HOLD_CYCLES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OTP_W-1:0]   otp_in,
  input  logic               otp_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               key_valid,
  input  logic               key_clear,
  output logic               unlock,
  output logic               expired,
  output logic               lockout,
  output logic [ATT_W-1:0]   attempts,
  output logic [CNT_W-1:0]   entry_count,
  output logic [OTP_W-1:0]   otp,
  output logic [OTP_W-1:0]   entry_out
);

  state_e             state_r, state_n;
  logic [TIMER_W-1:0] timer_r, timer_n;
  logic [HOLD_W-1:0]  hold_r, hold_n;
  logic [OTP_W-1:0]   otp_r, otp_n;
  logic [ATT_W-1:0]   att_r, att_n;
  logic               unlock_r, unlock_n, expired_r, expired_n, lockout_r, lockout_n;
  logic               buf_wr_s, buf_clr_s, buf_full_s;
  logic [OTP_W-1:0]   buf_entry_s;
  logic [CNT_W-1:0]   buf_count_s;

  otp_entry_buf #(.N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W)) u_buf (
    .clk   (clk),
    .reset (reset),
    .wr    (buf_wr_s),
    .clr   (buf_clr_s),
    .digit (key_digit),
    .entry (buf_entry_s),
    .count (buf_count_s),
    .full  (buf_full_s)
  );

  // Next-state and datapath control.
  always_comb begin
    state_n   = state_r;
    timer_n   = timer_r;
    hold_n    = hold_r;
    otp_n     = otp_r;
    att_n     = att_r;
    unlock_n  = unlock_r;
    expired_n = expired_r;
    lockout_n = lockout_r;
    buf_wr_s  = 1'b0;
    buf_clr_s = 1'b0;
    case (state_r)
      IDLE: begin
        timer_n   = {TIMER_W{1'b0}};
        hold_n    = {HOLD_W{1'b0}};
        otp_n     = {OTP_W{1'b0}};
        att_n     = {ATT_W{1'b0}};
        unlock_n  = 1'b0;
        expired_n = 1'b0;
        lockout_n = 1'b0;
        buf_clr_s = 1'b1;
        state_n   = LOAD;
      end
      LOAD: begin
        if (otp_valid) begin
          otp_n   = otp_in;
          timer_n = {TIMER_W{1'b0}};
          state_n = ENTER;
        end else begin
          state_n = LOAD;
        end
      end
      ENTER: begin
        // Expiry outranks any key activity in the same cycle.
        if (timer_r == TIMER_W'(EXPIRE_CYCLES - 64'd1)) begin
          expired_n = 1'b1;
          hold_n    = {HOLD_W{1'b0}};
          state_n   = EXPIRED;
        end else begin
          timer_n = timer_r + TIMER_W'(1'b1);
          if (key_clear) begin
            buf_clr_s = 1'b1;
          end else if (key_valid) begin
            buf_wr_s = 1'b1;
            if (buf_count_s == CNT_W'(N_DIGITS - 1)) begin
              state_n = CHECK;
            end else begin
              state_n = ENTER;
            end
          end else begin
            state_n = ENTER;
          end
        end
      end
      CHECK: begin
        hold_n = {HOLD_W{1'b0}};
        if (buf_full_s && (buf_entry_s == otp_r)) begin
          unlock_n = 1'b1;
          state_n  = UNLOCK;
        end else if ((att_r + ATT_W'(1'b1)) == ATT_W'(MAX_ATTEMPTS)) begin
          att_n     = ATT_W'(MAX_ATTEMPTS);
          lockout_n = 1'b1;
          state_n   = LOCKOUT;
        end else begin
          att_n     = att_r + ATT_W'(1'b1);
          buf_clr_s = 1'b1;
          state_n   = ENTER;
        end
      end
      UNLOCK, EXPIRED, LOCKOUT: begin
        if (hold_r == HOLD_W'(HOLD_CYCLES - 64'd1)) begin
          unlock_n  = 1'b0;
          expired_n = 1'b0;
          lockout_n = 1'b0;
          state_n   = IDLE;
        end else begin
          hold_n = hold_r + HOLD_W'(1'b1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      timer_r   <= {TIMER_W{1'b0}};
      hold_r    <= {HOLD_W{1'b0}};
      otp_r     <= {OTP_W{1'b0}};
      att_r     <= {ATT_W{1'b0}};
      unlock_r  <= 1'b0;
      expired_r <= 1'b0;
      lockout_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      timer_r   <= timer_n;
      hold_r    <= hold_n;
      otp_r     <= otp_n;
      att_r     <= att_n;
      unlock_r  <= unlock_n;
      expired_r <= expired_n;
      lockout_r <= lockout_n;
    end
  end

  assign unlock      = unlock_r;
  assign expired     = expired_r;
  assign lockout     = lockout_r;
  assign attempts    = att_r;
  assign otp         = otp_r;
  assign entry_out   = buf_entry_s;
  assign entry_count = buf_count_s;

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Scoreboard bench: stimulus queues expected output snapshots with their cycle,
// a negedge monitor pops one whenever any observed output changes.
module tb_otp_auth_ctrl;

  typedef struct packed {
    logic        unl;
    logic        exp;
    logic        lck;
    logic [1:0]  att;
    logic [2:0]  cnt;
    logic [15:0] ent;
    logic [15:0] otp;
  } obs_t;

  typedef struct {
    obs_t v;
    int   at;
  } exp_t;

  logic        clk, reset;
  logic [15:0] otp_in;
  logic        otp_valid;
  logic [3:0]  key_digit;
  logic        key_valid, key_clear;
  logic        unlock, expired, lockout;
  logic [1:0]  attempts;
  logic [2:0]  entry_count;
  logic [15:0] otp, entry_out;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   kc, lc;
  obs_t m, prev, o;
  exp_t e;
  exp_t q[$];

  otp_auth_ctrl #(
    .N_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(3),
    .EXPIRE_CYCLES(64'd200), .HOLD_CYCLES(64'd10)
  ) dut (
    .clk(clk), .reset(reset), .otp_in(otp_in), .otp_valid(otp_valid),
    .key_digit(key_digit), .key_valid(key_valid), .key_clear(key_clear),
    .unlock(unlock), .expired(expired), .lockout(lockout), .attempts(attempts),
    .entry_count(entry_count), .otp(otp), .entry_out(entry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the observed outputs must match the next queued snapshot.
  initial prev = '0;
  always @(negedge clk) begin
    o = {unlock, expired, lockout, attempts, entry_count, entry_out, otp};
    if (o !== prev) begin
      n_vec++;
      if (q.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_event cyc=%0d got=%h required=no change", cyc, o);
      end else begin
        e = q.pop_front();
        if (o !== e.v || cyc != e.at) begin
          n_miss++;
          $display("FAIL event: got unl=%0b exp=%0b lck=%0b att=%0d cnt=%0d ent=%h otp=%h at cyc %0d, required unl=%0b exp=%0b lck=%0b att=%0d cnt=%0d ent=%h otp=%h at cyc %0d",
                   o.unl, o.exp, o.lck, o.att, o.cnt, o.ent, o.otp, cyc,
                   e.v.unl, e.v.exp, e.v.lck, e.v.att, e.v.cnt, e.v.ent, e.v.otp, e.at);
        end
      end
    end
    prev = o;
  end

  task automatic push(input int at);
    exp_t x;
    x.v  = m;
    x.at = at;
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] v);
    otp_in = v; otp_valid = 1'b1; lc = cyc;
    m.otp = v; push(cyc + 1);
    @(negedge clk);
    otp_valid = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    int slot;
    key_digit = d; key_valid = 1'b1; kc = cyc;
    slot = 3 - int'(m.cnt);
    m.ent[slot*4 +: 4] = d;
    m.cnt = m.cnt + 3'd1;
    push(cyc + 1);
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic key_raw(input logic [3:0] d, input logic v, input logic c);
    key_digit = d; key_valid = v; key_clear = c;
    @(negedge clk);
    key_valid = 1'b0; key_clear = 1'b0;
  endtask

  task automatic clear_entry(input logic with_key);
    key_digit = 4'h9; key_valid = with_key; key_clear = 1'b1;
    m.ent = 16'h0000; m.cnt = 3'd0;
    push(cyc + 1);
    @(negedge clk);
    key_valid = 1'b0; key_clear = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] v);
    for (int i = 0; i < 4; i++) key(v[15-4*i -: 4]);
  endtask

  // Flag already pushed high at 'rise': it drops 10 cycles later, IDLE clears one cycle after.
  task automatic hold_tail(input int rise);
    m.unl = 1'b0; m.exp = 1'b0; m.lck = 1'b0;
    push(rise + 10);
    m = '0;
    push(rise + 11);
  endtask

  task automatic chk_zero(input string name);
    n_vec++;
    if ({unlock, expired, lockout, attempts, entry_count, entry_out, otp} !== 41'd0) begin
      n_miss++;
      $display("FAIL %s: got unl=%0b exp=%0b lck=%0b att=%0d cnt=%0d ent=%h otp=%h, required all 0",
               name, unlock, expired, lockout, attempts, entry_count, entry_out, otp);
    end
  endtask

  initial begin
    #50000;
    n_miss++;
    $display("FAIL watchdog: cyc=%0d, required bench to finish", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    m = '0;
    reset = 1'b1; otp_in = 16'h0000; otp_valid = 1'b0;
    key_digit = 4'h0; key_valid = 1'b0; key_clear = 1'b0;
    #1 reset = 1'b0;
    #2 chk_zero("reset_state");
    wait_cyc(3);
    reset = 1'b1;
    @(negedge clk);

    // Correct entry.
    load(16'h3A71);
    enter_code(16'h3A71);
    m.unl = 1'b1; push(kc + 2);
    hold_tail(kc + 2);
    wait_until(kc + 14);

    // Clear key, then clear together with key_valid.
    load(16'h3A71);
    key(4'h3); key(4'hA);
    clear_entry(1'b0);
    key(4'h5);
    clear_entry(1'b1);
    enter_code(16'h3A71);
    m.unl = 1'b1; push(kc + 2);
    hold_tail(kc + 2);
    wait_until(kc + 14);

    // Three wrong entries lead to lockout; keys during lockout are ignored.
    load(16'h3A71);
    for (int a = 0; a < 3; a++) begin
      enter_code(16'h1111);
      if (a < 2) begin
        m.att = 2'(a + 1); m.ent = 16'h0000; m.cnt = 3'd0;
        push(kc + 2);
        wait_cyc(2);
      end else begin
        m.lck = 1'b1; m.att = 2'd3;
        push(kc + 2);
      end
    end
    wait_cyc(2);
    key_raw(4'h5, 1'b1, 1'b0);
    key_raw(4'h0, 1'b0, 1'b1);
    hold_tail(kc + 2);
    wait_until(kc + 14);

    // Expiry on the 200th ENTER cycle; a key on that cycle is ignored.
    load(16'hB2C4);
    key(4'h2); key(4'h4);
    m.exp = 1'b1; push(lc + 201);
    hold_tail(lc + 201);
    wait_until(lc + 200);
    key_raw(4'h6, 1'b1, 1'b0);
    wait_until(lc + 214);

    // Expiry after a wrong entry: the CHECK cycle does not count, the timer is not reset.
    load(16'h7E05);
    wait_cyc(40);
    enter_code(16'h1111);
    m.att = 2'd1; m.ent = 16'h0000; m.cnt = 3'd0;
    push(kc + 2);
    m.exp = 1'b1; push(lc + 202);
    hold_tail(lc + 202);
    wait_until(lc + 215);

    // Reset mid-entry clears outputs asynchronously; LOAD then waits for otp_valid.
    load(16'h8C2E);
    key(4'h1); key(4'h2);
    m = '0; push(cyc + 1);
    #2 reset = 1'b0;
    #1 chk_zero("reset_async");
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(10);
    key_raw(4'h7, 1'b1, 1'b0);
    load(16'h55AA);
    key(4'h5);
    wait_cyc(5);

    n_vec++;
    if (q.size() != 0) begin
      n_miss++;
      $display("FAIL pending_events: got %0d left, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
